nibble_serial_loader: RTL and testbench
=======================================

# nibble_serial_loader

- Receives a 4-bit nibble over a single asynchronous serial line: start bit, 4 data bits LSB first, optional even-parity bit, stop bit.
- On each valid frame it presents the nibble on `Data` with a one-cycle `Enable` pulse.
- Sits directly upstream of the 4-bit enable-gated data register: `Data`/`Enable` connect straight to that register's `Data`/`Enable` inputs, and both blocks share `Clock` and `Reset`.
- Malformed frames are reported on error flags and never produce `Enable`.

## Interface

Parameters:
- `BIT_CYCLES`, default 4: clock cycles per serial bit; legal range ≥ 2. H = `BIT_CYCLES`/2 (integer division).
- `PARITY_EN`, default 1: 1 = the frame carries an even-parity bit after D3; 0 = no parity bit.

Ports:
- `Clock`  in  1: single clock; all state updates on the rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `SerIn`  in  1: serial line, idle high; already synchronous to `Clock`.
- `Data`  out  4: last successfully received nibble.
- `Enable`  out  1: one-cycle load strobe to the downstream register.
- `ParityErr`  out  1: one-cycle pulse on parity mismatch.
- `FrameErr`  out  1: one-cycle pulse when the stop bit samples low.
- `Busy`  out  1: high whenever state ≠ IDLE.

## Operation

- States: IDLE, START, DATA, PARITY, STOP, LOAD, BREAK.
  - IDLE: first cycle with `SerIn`=0 → START; a cycle counter is loaded.
  - START: the sample at H cycles re-checks `SerIn`.
    - 1 → false start; return to IDLE with no flags.
    - 0 → DATA.
  - DATA: one sample every `BIT_CYCLES` cycles; D0..D3 go into a shift register, LSB first. After D3 → PARITY if `PARITY_EN`, else STOP.
  - PARITY: one sample; check passes when XOR(D3..D0, P) = 0.
  - STOP: one sample.
    - Stop = 1 and parity OK (or disabled) → LOAD.
    - Stop = 1 and parity bad → `ParityErr` pulse → IDLE.
    - Stop = 0 → `FrameErr` pulse, plus `ParityErr` if parity was also bad → BREAK.
  - LOAD: `Data` ← shift register, `Enable`=1 for exactly this cycle → IDLE.
  - BREAK: wait for `SerIn`=1 → IDLE. A held-low line never re-triggers.
- `Data` changes only on the LOAD cycle and holds between frames, including across errored frames.
- The error flags and `Enable` are mutually exclusive and never high for more than one cycle.
- Reset, asynchronous at any time including mid-frame:
  - state → IDLE
  - `Data`=0, `Enable`=0, `ParityErr`=0, `FrameErr`=0, `Busy`=0
  - counters and shift register cleared.
- After `Reset` deasserts, start detection begins on the next rising edge.

## Timing

- t0 = first IDLE cycle in which `SerIn`=0 is seen. B = `BIT_CYCLES`.
- Sample points (value captured at the edge ending the cycle):
  - start check at t0+H
  - Dk at t0+H+(k+1)·B, for k = 0..3
  - parity at t0+H+5B
  - stop at t0+H+6B with parity, t0+H+5B without.
- `Enable`, `ParityErr` and `FrameErr` assert in the cycle after the stop sample.
  - B=4, parity on: t0+27. B=4, parity off: t0+23.
- `Busy` rises at t0+1 and falls the cycle after LOAD, or after the error return to IDLE.
- Back-to-back frames: a start bit may begin on the cycle `Busy` falls; no idle gap is required beyond the stop bit.
- The sample counter wraps modulo B with no drift across frames.

## Test plan

All scenarios use `BIT_CYCLES`=4 unless noted.

- **Reset:**
  - Assert `Reset` at power-up → all outputs 0.
  - Assert `Reset` at t0+12 mid-frame → `Busy`=0 immediately (asynchronous), no `Enable`.
  - Send the next frame after release → received normally.
- **Good frame:** nibble 4'b1011 sent as bits 1,1,0,1, P=1, stop=1 → `Enable`=1 only at t0+27, `Data`=4'b1011, no error flags.
- **Parity error:**
  - First receive 4'b1011; then send 4'b0110 with P=1 → `ParityErr` pulse at t0+27.
  - Required: `Enable` stays 0 and `Data` remains 4'b1011.
- **Frame error and break:**
  - Send a frame with stop=0, then hold `SerIn`=0 for 40 cycles → `FrameErr` single pulse at t0+27, `Busy` stays 1 through the hold.
  - Raise `SerIn` → `Busy` falls; the next frame is received.
- **False start:** `SerIn` low for 1 cycle → `Busy` high for H cycles, then returns to IDLE with no flags and `Data` unchanged.
- **Sweep:**
  - All 16 nibbles 0000..1111 back-to-back, `PARITY_EN`=1 and `PARITY_EN`=0 → 16 `Enable` pulses, each with `Data` equal to the sent nibble.
  - Repeat with `BIT_CYCLES`=2 and 7.

Source files
------------

// File: rtl/nibble_serial_loader_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// nibble_serial_loader_if : serial line in, nibble/strobe/status out.
// Rev 1.0
// ----------------------------------------------------------------------
interface nibble_serial_loader_if;
  logic       SerIn;
  logic [3:0] Data;
  logic       Enable;
  logic       ParityErr;
  logic       FrameErr;
  logic       Busy;

  modport master (
    input  SerIn,
    output Data, Enable, ParityErr, FrameErr, Busy
  );

  modport slave (
    output SerIn,
    input  Data, Enable, ParityErr, FrameErr, Busy
  );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_loader.sv
`default_nettype none
// ----------------------------------------------------------------------
// nibble_serial_loader : async-serial nibble receiver that strobes a
// downstream 4-bit enable-gated register.   Rev 1.0
// ----------------------------------------------------------------------
module nibble_serial_loader #(
  parameter int BIT_CYCLES = 4,
  parameter bit PARITY_EN  = 1'b1
) (
  input  logic                   Clock,
  input  logic                   Reset,
  nibble_serial_loader_if.master bus
);

  localparam int               CNT_W     = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    LOAD   = 3'd5,
    BREAK  = 3'd6
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       shreg, shreg_n;
  logic [1:0]       bit_idx, bit_n;
  logic             par_bad, par_bad_n;
  logic [3:0]       data_q, data_n;
  logic             enable_q, enable_n;
  logic             perr_q, perr_n;
  logic             ferr_q, ferr_n;
  logic             tick;

  // Counter is reloaded at every sample, so each sample lands exactly B cycles after the last.
  assign tick = (cnt == '0);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      shreg    <= 4'd0;
      bit_idx  <= 2'd0;
      par_bad  <= 1'b0;
      data_q   <= 4'd0;
      enable_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_n;
      par_bad  <= par_bad_n;
      data_q   <= data_n;
      enable_q <= enable_n;
      perr_q   <= perr_n;
      ferr_q   <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shreg_n   = shreg;
    bit_n     = bit_idx;
    par_bad_n = par_bad;
    data_n    = data_q;
    enable_n  = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;

    case (state)
      IDLE: begin
        if (!bus.SerIn) begin
          state_n = START;
          cnt_n   = HALF_LOAD;
        end
      end

      START: begin
        if (tick) begin
          if (bus.SerIn) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            cnt_n     = BIT_LOAD;
            bit_n     = 2'd0;
            par_bad_n = 1'b0;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      DATA: begin
        if (tick) begin
          shreg_n = {bus.SerIn, shreg[3:1]};
          bit_n   = bit_idx + 2'd1;
          cnt_n   = BIT_LOAD;
          if (bit_idx == 2'd3) begin
            state_n = PARITY_EN ? PARITY : STOP;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      PARITY: begin
        if (tick) begin
          par_bad_n = ^{shreg, bus.SerIn};
          cnt_n     = BIT_LOAD;
          state_n   = STOP;
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      STOP: begin
        if (tick) begin
          if (bus.SerIn && !par_bad) begin
            state_n  = LOAD;
            data_n   = shreg;
            enable_n = 1'b1;
          end else if (bus.SerIn) begin
            state_n = IDLE;
            perr_n  = 1'b1;
          end else begin
            state_n = BREAK;
            ferr_n  = 1'b1;
            perr_n  = par_bad;
          end
        end else begin
          cnt_n = cnt - CNT_ONE;
        end
      end

      LOAD: state_n = IDLE;

      // A line stuck low must go high again before a new start can be seen.
      BREAK: begin
        if (bus.SerIn) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign bus.Data      = data_q;
  assign bus.Enable    = enable_q;
  assign bus.ParityErr = perr_q;
  assign bus.FrameErr  = ferr_q;
  assign bus.Busy      = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_loader.sv
`default_nettype none
// Self-checking bench: table of frames on a B=4/parity DUT, directed corner
// sequences, and a 16-nibble sweep over six parameter sets.
module tb_nibble_serial_loader;

  typedef struct {
    logic [3:0] nib;
    bit         pflip;
    bit         stop;
    logic [2:0] flags;   // {Enable, ParityErr, FrameErr}
    logic [3:0] data;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [2:0] flags;
    logic [3:0] data;
  } evt_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   sweep_go = 1'b0;
  int   sweep_finished = 0;

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  nibble_serial_loader_if bus ();
  nibble_serial_loader #(.BIT_CYCLES(4), .PARITY_EN(1'b1)) u_dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- main DUT scoreboard ----------------
  evt_t       exp_q[$];
  evt_t       ev;
  logic [3:0] prev_data = 4'd0;

  always @(negedge Clock) begin
    if (Reset) begin
      prev_data <= 4'd0;
    end else begin
      if (bus.Enable || bus.ParityErr || bus.FrameErr) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_event: got flags %b at cycle %0d, expected none",
                   {bus.Enable, bus.ParityErr, bus.FrameErr}, cyc);
        end else begin
          ev = exp_q.pop_front();
          check("event_cycle", cyc, ev.cyc);
          check("event_flags", int'({bus.Enable, bus.ParityErr, bus.FrameErr}), int'(ev.flags));
          check("event_data", int'(bus.Data), int'(ev.data));
        end
      end
      if (bus.Data !== prev_data) begin
        check("data_changes_only_on_enable", int'(bus.Enable), 1);
      end
      prev_data <= bus.Data;
    end
  end

  // Caller must be at a negedge. Waits for IDLE, then drives one framed nibble.
  task automatic send_frame(input logic [3:0] nib, input bit pflip, input bit stop,
                            input logic [2:0] flags, input logic [3:0] data);
    logic [6:0] bits;
    int         guard;
    evt_t       e;
    guard = 0;
    while (bus.Busy && guard < 200) begin
      @(negedge Clock);
      guard++;
    end
    check("idle_before_frame", int'(bus.Busy), 0);
    bits    = {stop, (^nib) ^ pflip, nib, 1'b0};
    e.cyc   = cyc + 27;
    e.flags = flags;
    e.data  = data;
    exp_q.push_back(e);
    for (int k = 0; k < 7; k++) begin
      bus.SerIn = bits[k];
      repeat (4) @(negedge Clock);
    end
  endtask

  // ---------------- sweep instances ----------------
  for (genvar gi = 0; gi < 6; gi++) begin : g_sweep
    localparam int SB   = (gi < 2) ? 4 : ((gi < 4) ? 2 : 7);
    localparam bit SP   = ((gi % 2) == 0);
    localparam int SLAT = SB / 2 + (SP ? 6 : 5) * SB + 1;

    nibble_serial_loader_if sbus ();
    nibble_serial_loader #(.BIT_CYCLES(SB), .PARITY_EN(SP)) u_sdut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (sbus)
    );

    evt_t sq[$];
    evt_t se;
    int   got = 0;

    always @(negedge Clock) begin
      if (sweep_go && !Reset) begin
        if (sbus.ParityErr || sbus.FrameErr) begin
          check($sformatf("sweep%0d_err_flag", gi),
                int'({sbus.ParityErr, sbus.FrameErr}), 0);
        end
        if (sbus.Enable) begin
          got++;
          if (sq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sweep%0d_unexpected_enable: got Enable at cycle %0d, expected none",
                     gi, cyc);
          end else begin
            se = sq.pop_front();
            check($sformatf("sweep%0d_cycle", gi), cyc, se.cyc);
            check($sformatf("sweep%0d_data", gi), int'(sbus.Data), int'(se.data));
          end
        end
      end
    end

    initial begin
      logic [6:0] fb;
      logic [3:0] nib;
      int         nb;
      int         guard;
      evt_t       e;
      sbus.SerIn = 1'b1;
      wait (sweep_go);
      @(negedge Clock);
      for (int n = 0; n < 16; n++) begin
        nib   = 4'(n);
        guard = 0;
        while (sbus.Busy && guard < 200) begin
          @(negedge Clock);
          guard++;
        end
        if (SP) begin
          fb = {1'b1, ^nib, nib, 1'b0};
          nb = 7;
        end else begin
          fb = {1'b0, 1'b1, nib, 1'b0};
          nb = 6;
        end
        e.cyc   = cyc + SLAT;
        e.flags = 3'b100;
        e.data  = nib;
        sq.push_back(e);
        for (int k = 0; k < nb; k++) begin
          sbus.SerIn = fb[k];
          repeat (SB) @(negedge Clock);
        end
        sbus.SerIn = 1'b1;
      end
      guard = 0;
      while (sq.size() != 0 && guard < SLAT + 10) begin
        @(negedge Clock);
        guard++;
      end
      check($sformatf("sweep%0d_enable_count", gi), got, 16);
      check($sformatf("sweep%0d_queue_empty", gi), sq.size(), 0);
      sweep_finished++;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t vt[8];
    int   t0;
    int   busy_low;

    vt[0] = '{4'b1011, 1'b0, 1'b1, 3'b100, 4'b1011};
    vt[1] = '{4'b0110, 1'b1, 1'b1, 3'b010, 4'b1011};
    vt[2] = '{4'b0000, 1'b0, 1'b1, 3'b100, 4'b0000};
    vt[3] = '{4'b1111, 1'b0, 1'b0, 3'b001, 4'b0000};
    vt[4] = '{4'b0101, 1'b1, 1'b0, 3'b011, 4'b0000};
    vt[5] = '{4'b1001, 1'b0, 1'b1, 3'b100, 4'b1001};
    vt[6] = '{4'b0011, 1'b1, 1'b1, 3'b010, 4'b1001};
    vt[7] = '{4'b1110, 1'b0, 1'b1, 3'b100, 4'b1110};

    bus.SerIn = 1'b1;
    Reset     = 1'b1;
    repeat (3) @(negedge Clock);
    check("rst_data", int'(bus.Data), 0);
    check("rst_enable", int'(bus.Enable), 0);
    check("rst_parity_err", int'(bus.ParityErr), 0);
    check("rst_frame_err", int'(bus.FrameErr), 0);
    check("rst_busy", int'(bus.Busy), 0);
    Reset = 1'b0;
    @(negedge Clock);

    // Table of frames, sent back to back
    for (int i = 0; i < 8; i++) begin
      send_frame(vt[i].nib, vt[i].pflip, vt[i].stop, vt[i].flags, vt[i].data);
      if (!vt[i].stop) begin
        check("busy_in_break", int'(bus.Busy), 1);
        bus.SerIn = 1'b1;
        @(negedge Clock);
      end
    end
    repeat (3) @(negedge Clock);
    check("table_events_drained", exp_q.size(), 0);

    // False start: one low cycle keeps Busy for H=2 cycles only
    bus.SerIn = 1'b0;
    @(negedge Clock);
    bus.SerIn = 1'b1;
    check("false_start_busy_t1", int'(bus.Busy), 1);
    @(negedge Clock);
    check("false_start_busy_t2", int'(bus.Busy), 1);
    @(negedge Clock);
    check("false_start_busy_t3", int'(bus.Busy), 0);
    check("false_start_data", int'(bus.Data), 4'b1110);

    // Frame error then 40 cycles of held-low line
    send_frame(4'b1100, 1'b0, 1'b0, 3'b001, 4'b1110);
    busy_low = 0;
    repeat (40) begin
      @(negedge Clock);
      if (!bus.Busy) busy_low++;
    end
    check("break_busy_low_cycles", busy_low, 0);
    bus.SerIn = 1'b1;
    @(negedge Clock);
    check("break_release_busy", int'(bus.Busy), 0);
    send_frame(4'b0111, 1'b0, 1'b1, 3'b100, 4'b0111);

    // Asynchronous reset at t0+12 of a frame in flight
    bus.SerIn = 1'b0;
    t0 = cyc;
    repeat (4) @(negedge Clock);
    bus.SerIn = 1'b1;
    repeat (4) @(negedge Clock);
    bus.SerIn = 1'b0;
    repeat (4) @(negedge Clock);
    check("midframe_t0_offset", cyc - t0, 12);
    #2;
    Reset     = 1'b1;
    bus.SerIn = 1'b1;
    #1;
    check("async_rst_busy", int'(bus.Busy), 0);
    check("async_rst_data", int'(bus.Data), 0);
    check("async_rst_enable", int'(bus.Enable), 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    send_frame(4'b1010, 1'b0, 1'b1, 3'b100, 4'b1010);
    repeat (3) @(negedge Clock);
    check("main_events_drained", exp_q.size(), 0);

    // Parameter sweep on the side instances
    sweep_go = 1'b1;
    for (int g = 0; g < 4000 && sweep_finished < 6; g++) @(negedge Clock);
    check("sweep_instances_finished", sweep_finished, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
